// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the multi-lane decode-stage register file.
// Default widths here seed the module parameters; override them per instance.
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_LANES  = 2;

  typedef logic [RF_ADDR_WIDTH-1:0]         reg_idx_t;
  typedef logic [RF_DATA_WIDTH-1:0]         reg_data_t;
  typedef logic [$clog2(RF_NUM_LANES)-1:0]  lane_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // Register 0 is hardwired: never written, never busy.
  function automatic logic is_zero_idx(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue and
// cleared by writeback, with set taking priority in the same cycle.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_LANES  = RF_NUM_LANES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_LANES-1:0]              we,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_LANES-1:0]              issue_valid,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   issue_rd,
  input  logic [2*NUM_LANES*ADDR_WIDTH-1:0] raddr,
  output logic [2*NUM_LANES-1:0]            o_busy
);

  localparam int NREGS  = 2**ADDR_WIDTH;
  localparam int NPORTS = 2*NUM_LANES;

  logic [NREGS-1:0]      r_busy;
  logic [NREGS-1:0]      w_busy_nxt;
  logic [ADDR_WIDTH-1:0] w_waddr    [NUM_LANES];
  logic [ADDR_WIDTH-1:0] w_issue_rd [NUM_LANES];
  logic [ADDR_WIDTH-1:0] w_raddr    [NPORTS];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign w_waddr[i]    = waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_issue_rd[i] = issue_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign w_raddr[p] = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Clears are applied before sets so a new producer outranks a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we[i] && (w_waddr[i] != '0)) begin
        w_busy_nxt[w_waddr[i]] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (issue_valid[i] && (w_issue_rd[i] != '0)) begin
        w_busy_nxt[w_issue_rd[i]] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int p = 0; p < NPORTS; p++) begin
      o_busy[p] = r_busy[w_raddr[p]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-lane integer register file: 2 read + 1 write port per lane, youngest
// lane wins write conflicts, optional write-to-read bypass, RAW scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_LANES  = RF_NUM_LANES,
  parameter int BYPASS     = 1,
  parameter int DEBUG_REG  = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_LANES-1:0]              we,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   waddr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   wdata,
  input  logic [2*NUM_LANES*ADDR_WIDTH-1:0] raddr,
  output logic [2*NUM_LANES*DATA_WIDTH-1:0] rdata,
  output logic [2*NUM_LANES-1:0]            rbusy,
  input  logic [NUM_LANES-1:0]              issue_valid,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   issue_rd,
  output logic [DATA_WIDTH-1:0]             dbg_reg
);

  localparam int                    NREGS   = 2**ADDR_WIDTH;
  localparam int                    NPORTS  = 2*NUM_LANES;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DEBUG_REG);

  logic [DATA_WIDTH-1:0] r_regs     [NREGS];
  logic [ADDR_WIDTH-1:0] w_waddr    [NUM_LANES];
  logic [DATA_WIDTH-1:0] w_wdata    [NUM_LANES];
  logic [ADDR_WIDTH-1:0] w_issue_rd [NUM_LANES];
  logic [ADDR_WIDTH-1:0] w_raddr    [NPORTS];
  logic [DATA_WIDTH-1:0] w_rdata    [NPORTS];
  logic [NPORTS-1:0]     w_byp_hit;
  logic [NPORTS-1:0]     w_iss_hit;
  logic [NPORTS-1:0]     w_busy_raw;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign w_waddr[i]    = waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[i]    = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_issue_rd[i] = issue_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign w_raddr[p]                        = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = w_rdata[p];
  end

  // Lanes are visited oldest first, so the youngest lane's write lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we[i] && !is_zero_idx(reg_idx_t'(w_waddr[i]))) begin
          r_regs[w_waddr[i]] <= w_wdata[i];
        end
      end
    end
  end

  always_comb begin
    w_byp_hit = '0;
    w_iss_hit = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_rdata[p] = r_regs[w_raddr[p]];
      for (int i = 0; i < NUM_LANES; i++) begin
        if ((BYPASS != 0) && we[i] && (w_waddr[i] == w_raddr[p])) begin
          w_rdata[p]   = w_wdata[i];
          w_byp_hit[p] = 1'b1;
        end
        if (issue_valid[i] && (w_issue_rd[i] == w_raddr[p])) begin
          w_iss_hit[p] = 1'b1;
        end
      end
      if (w_raddr[p] == '0) begin
        w_rdata[p]   = '0;
        w_byp_hit[p] = 1'b0;
        w_iss_hit[p] = 1'b0;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_LANES  (NUM_LANES)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .waddr       (waddr),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .raddr       (raddr),
    .o_busy      (w_busy_raw)
  );

  // A retiring write hides the busy bit unless a new producer is issued too.
  assign rbusy   = w_busy_raw & ~(w_byp_hit & ~w_iss_hit);
  assign dbg_reg = r_regs[DBG_IDX];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (2 lanes, 32x32, bypass on).
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NL = 2;
  localparam int NP = 2*NL;

  logic              clk;
  logic              reset;
  logic [NL-1:0]     we;
  logic [NL*AW-1:0]  waddr;
  logic [NL*DW-1:0]  wdata;
  logic [NP*AW-1:0]  raddr;
  logic [NP*DW-1:0]  rdata;
  logic [NP-1:0]     rbusy;
  logic [NL-1:0]     issue_valid;
  logic [NL*AW-1:0]  issue_rd;
  logic [DW-1:0]     dbg_reg;

  int n_tests;
  int n_fail;

  reg_file_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_LANES  (NL),
    .BYPASS     (1),
    .DEBUG_REG  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .dbg_reg     (dbg_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    issue_valid = '0;
    issue_rd    = '0;
  endtask

  task automatic set_w(input int lane, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[lane]              = 1'b1;
    waddr[lane*AW +: AW]  = a;
    wdata[lane*DW +: DW]  = d;
  endtask

  task automatic set_iss(input int lane, input logic [AW-1:0] rd);
    issue_valid[lane]        = 1'b1;
    issue_rd[lane*AW +: AW]  = rd;
  endtask

  task automatic set_r(input int port, input logic [AW-1:0] a);
    raddr[port*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd_port(input int port);
    return rdata[port*DW +: DW];
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    raddr   = '0;
    idle();
    tick();
    tick();

    // reset state: every index on every port
    for (int idx = 0; idx < 32; idx++) begin
      for (int p = 0; p < NP; p++) set_r(p, AW'(idx));
      #1;
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rst_rdata_x%0d_p%0d", idx, p), rd_port(p), 32'h0);
        chk($sformatf("rst_rbusy_x%0d_p%0d", idx, p), {31'b0, rbusy[p]}, 32'h0);
      end
    end
    chk("rst_dbg", dbg_reg, 32'h0);
    reset = 1'b0;
    tick();

    // write conflict: youngest lane wins, bypass returns it same cycle
    set_w(0, 5'd5, 32'h11);
    set_w(1, 5'd5, 32'h22);
    set_r(0, 5'd5);
    set_r(3, 5'd5);
    #1;
    chk("conf_byp_p0", rd_port(0), 32'h22);
    chk("conf_byp_p3", rd_port(3), 32'h22);
    tick();
    idle();
    #1;
    chk("conf_stored_p0", rd_port(0), 32'h22);
    chk("conf_stored_p3", rd_port(3), 32'h22);

    // x0 is hardwired
    set_w(0, 5'd0, 32'hFFFF_FFFF);
    set_w(1, 5'd0, 32'hFFFF_FFFF);
    set_iss(0, 5'd0);
    set_iss(1, 5'd0);
    for (int p = 0; p < NP; p++) set_r(p, 5'd0);
    #1;
    for (int p = 0; p < NP; p++) chk($sformatf("x0_byp_p%0d", p), rd_port(p), 32'h0);
    tick();
    idle();
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("x0_rdata_p%0d", p), rd_port(p), 32'h0);
      chk($sformatf("x0_rbusy_p%0d", p), {31'b0, rbusy[p]}, 32'h0);
    end

    // scoreboard set by issue, cleared by writeback
    set_iss(1, 5'd7);
    set_r(0, 5'd7);
    #1;
    chk("x7_busy_same_cycle", {31'b0, rbusy[0]}, 32'h0);
    tick();
    idle();
    #1;
    chk("x7_busy_after_issue", {31'b0, rbusy[0]}, 32'h1);
    set_w(0, 5'd7, 32'hABCD);
    #1;
    chk("x7_busy_byp_clear", {31'b0, rbusy[0]}, 32'h0);
    chk("x7_rdata_byp", rd_port(0), 32'hABCD);
    tick();
    idle();
    #1;
    chk("x7_busy_after_wb", {31'b0, rbusy[0]}, 32'h0);
    chk("x7_rdata_after_wb", rd_port(0), 32'hABCD);

    // write and issue same register in one cycle: set wins
    set_w(0, 5'd9, 32'h99);
    set_iss(1, 5'd9);
    set_r(1, 5'd9);
    #1;
    chk("x9_rdata_byp", rd_port(1), 32'h99);
    chk("x9_busy_same", {31'b0, rbusy[1]}, 32'h0);
    tick();
    idle();
    #1;
    chk("x9_rdata", rd_port(1), 32'h99);
    chk("x9_busy_set", {31'b0, rbusy[1]}, 32'h1);
    set_w(1, 5'd9, 32'h9A);
    set_iss(0, 5'd9);
    #1;
    chk("x9_busy_reissue_same", {31'b0, rbusy[1]}, 32'h1);
    tick();
    idle();
    #1;
    chk("x9_busy_reissue", {31'b0, rbusy[1]}, 32'h1);
    chk("x9_rdata2", rd_port(1), 32'h9A);
    set_w(1, 5'd9, 32'h9B);
    tick();
    idle();
    #1;
    chk("x9_busy_cleared", {31'b0, rbusy[1]}, 32'h0);

    // debug register tracks storage, no bypass
    set_w(1, 5'd10, 32'h1234);
    #1;
    chk("dbg_same_cycle", dbg_reg, 32'h0);
    tick();
    idle();
    #1;
    chk("dbg_after", dbg_reg, 32'h1234);

    // mid-stream reset with activity
    set_iss(0, 5'd3);
    tick();
    idle();
    set_r(2, 5'd3);
    #1;
    chk("x3_busy_pre_rst", {31'b0, rbusy[2]}, 32'h1);
    reset = 1'b1;
    set_w(0, 5'd4, 32'h55);
    set_iss(1, 5'd6);
    tick();
    reset = 1'b0;
    idle();
    set_r(0, 5'd5);
    set_r(1, 5'd4);
    set_r(2, 5'd3);
    set_r(3, 5'd6);
    #1;
    chk("mrst_x5", rd_port(0), 32'h0);
    chk("mrst_x4", rd_port(1), 32'h0);
    chk("mrst_busy_x3", {31'b0, rbusy[2]}, 32'h0);
    chk("mrst_busy_x6", {31'b0, rbusy[3]}, 32'h0);
    chk("mrst_dbg", dbg_reg, 32'h0);
    set_r(0, 5'd7);
    set_r(1, 5'd9);
    #1;
    chk("mrst_x7", rd_port(0), 32'h0);
    chk("mrst_x9", rd_port(1), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-lane integer register file for the decode stage, generalising the two-lane register file to NUM_LANES issue lanes. Each lane has two read ports and one write port. The block adds lane-priority write conflict resolution, optional same-cycle write-to-read bypass, and a pending-write scoreboard so the issue logic can stall on RAW hazards. It sits between decode (read/issue) and writeback (write/release).

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers
- NUM_LANES, 2, issue/writeback lanes; lane 0 oldest in program order
- BYPASS, 1, 1 = reads return same-cycle write data; 0 = reads see registered state only
- DEBUG_REG, 10, index driven onto dbg_reg (a0 by default)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- we  in  NUM_LANES  per-lane write enable
- waddr  in  NUM_LANES x ADDR_WIDTH  per-lane write index
- wdata  in  NUM_LANES x DATA_WIDTH  per-lane write data
- raddr  in  2·NUM_LANES x ADDR_WIDTH  read index; port 2i = rs1 of lane i, 2i+1 = rs2
- rdata  out  2·NUM_LANES x DATA_WIDTH  read data
- rbusy  out  2·NUM_LANES  read index has a pending (issued, not written back) producer
- issue_valid  in  NUM_LANES  lane issues an instruction that writes rd
- issue_rd  in  NUM_LANES x ADDR_WIDTH  destination of issuing instruction
- dbg_reg  out  DATA_WIDTH  registers[DEBUG_REG], registered state, no bypass

## Operation
- Register 0: reads always 0, writes ignored, never busy; applies to both bypass and scoreboard.
- Writes: on rising clk, every lane with we=1 and waddr≠0 updates its register. If two or more lanes target the same index, the highest-numbered (youngest) lane wins; the others are dropped.
- Reads: combinational. BYPASS=1: if any lane writes the read index this cycle (we=1, index≠0), return wdata of the highest such lane; else the stored value. BYPASS=0: stored value only.
- Scoreboard: one busy bit per register.
  - Set: issue_valid[i] with issue_rd[i]≠0 sets busy[issue_rd[i]] at the edge.
  - Clear: we[i] with waddr[i]≠0 clears busy[waddr[i]] at the edge.
  - Same register both set and cleared in one cycle: set wins (new producer outstanding).
  - rbusy[p] = busy[raddr[p]]; BYPASS=1 forces rbusy[p]=0 when a same-cycle write hits raddr[p] and no same-cycle issue targets it.
- Scoreboard tracks one outstanding producer per register; issue logic must not issue a second writer to a busy rd (WAW). The block does not check this.
- Reset: all registers 0, all busy bits 0; writes and issues in the reset cycle are ignored.

## Timing
- Read latency 0 cycles (combinational from raddr/we/waddr/wdata).
- Write visible: same cycle through bypass (BYPASS=1), on storage output the cycle after the edge.
- Busy set/clear visible on rbusy the cycle after the edge; no same-cycle issue-to-rbusy path.
- dbg_reg updates one cycle after the write edge.
- Reset values: rdata 0 for all ports while reset held and inputs quiet; rbusy 0; dbg_reg 0 from the first edge with reset=1.
- Reset asserted mid-operation: the next edge clears all state regardless of we/issue_valid.

## Structure
- Shared package reg_file_pkg: DATA_WIDTH, ADDR_WIDTH, NUM_LANES defaults, typedefs reg_idx_t, reg_data_t, lane_idx_t, constant REG_ZERO.
- Sub-module rf_scoreboard: busy-bit array, set/clear priority, rbusy lookup. Parameters ADDR_WIDTH and NUM_LANES.
- Storage, write priority mux and bypass mux live in reg_file_mp.

## Test plan
- Reset then read all 32 indices on every port -> rdata 0, rbusy 0, dbg_reg 0.
- Lane 0 writes x5=0x11, lane 1 writes x5=0x22 same cycle -> next cycle x5 reads 0x22. BYPASS=1: same-cycle read of x5 returns 0x22.
- Write x0=0xFFFF_FFFF on all lanes with issue_rd=0 -> x0 reads 0 on all ports, rbusy for x0 stays 0.
- Issue rd=x7 on lane 1, then read x7 -> rbusy=1 from next cycle. Write x7=0xABCD on lane 0 -> rbusy 0 after the edge (same cycle with BYPASS=1), data 0xABCD.
- Same cycle: write x9 on lane 0 and issue rd=x9 on lane 1 -> x9 holds new data, busy[x9]=1.
- Write x10=0x1234 -> dbg_reg=0x1234 next cycle. Assert reset mid-stream with we active -> all registers and busy bits 0 after the edge.
